conv_window_feeder: RTL

CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

---
 rtl/conv_window_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/conv_window_feeder.sv
// Raster-order 3x3 window generator feeding a convolution cell from two line buffers.
// Optional macro CONV_FEEDER_STRIDE2_EN restricts emitted windows to stride 2.
module conv_window_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                  C_IN_CLK,
  input  logic                  C_IN_RST,
  input  logic                  C_IN_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] D_IN_DATA,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_1,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_2,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_3,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_4,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_5,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_6,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_7,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_8,
  output logic [DATA_WIDTH-1:0] D_OUT_DATA_9,
  output logic                  C_OUT_DATA_VALID,
  output logic                  C_OUT_FRAME_DONE,
  output logic                  C_OUT_BUSY
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [DATA_WIDTH-1:0]   win_q [9];
  logic [DATA_WIDTH-1:0]   win_d [9];
  logic                    valid_q, valid_d;

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2, both indexed by column.
  logic [DATA_WIDTH-1:0]   lb1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   lb2_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   lb1_rd, lb2_rd;

  logic                    col_last, row_last, emit;

  assign lb1_rd   = lb1_mem[col_q];
  assign lb2_rd   = lb2_mem[col_q];
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

`ifdef CONV_FEEDER_STRIDE2_EN
  // (row-2) and (col-2) even is the same as row and col even.
  assign emit = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) && !row_q[0] && !col_q[0];
`else
  assign emit = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;

    if (C_IN_DATA_VALID) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = D_IN_DATA;
      valid_d  = emit;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    unique case (state_q)
      IDLE: if (C_IN_DATA_VALID) state_d = FILL;
      FILL: if (C_IN_DATA_VALID && (row_q == ROW_W'(2)) && (col_q == '0)) state_d = RUN;
      RUN:  if (C_IN_DATA_VALID && row_last && col_last) state_d = DONE;
      DONE: state_d = C_IN_DATA_VALID ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge C_IN_CLK or posedge C_IN_RST) begin
    if (C_IN_RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: line buffers are deliberately not reset; rows 0 and 1 of every frame overwrite them before use.
  always_ff @(posedge C_IN_CLK) begin
    if (C_IN_DATA_VALID) begin
      lb2_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= D_IN_DATA;
    end
  end

  assign D_OUT_DATA_1     = win_q[0];
  assign D_OUT_DATA_2     = win_q[1];
  assign D_OUT_DATA_3     = win_q[2];
  assign D_OUT_DATA_4     = win_q[3];
  assign D_OUT_DATA_5     = win_q[4];
  assign D_OUT_DATA_6     = win_q[5];
  assign D_OUT_DATA_7     = win_q[6];
  assign D_OUT_DATA_8     = win_q[7];
  assign D_OUT_DATA_9     = win_q[8];
  assign C_OUT_DATA_VALID = valid_q;
  assign C_OUT_FRAME_DONE = (state_q == DONE);
  assign C_OUT_BUSY       = (state_q != IDLE);

endmodule
